// File: rtl/wrs_pkg.sv
// wrs_pkg: shared widths and state encoding for the result write scheduler
package wrs_pkg;
    localparam int DW_DEF = 25;
    localparam int IW_DEF = 10;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;
endpackage

// File: rtl/wrs_fifo.sv
// wrs_fifo: synchronous FIFO with combinational head read; push when full and pop when empty are ignored
module wrs_fifo #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wptr, rptr;
    logic do_push, do_pop;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty = wptr == rptr;
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign dout  = mem[rptr[AW-1:0]];
    // storage write at the tail
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= din;
    end
    // head and tail pointers, extra msb distinguishes full from empty
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop) rptr <= rptr + 1'b1;
        end
    end
endmodule

// File: rtl/result_write_scheduler.sv
// result_write_scheduler: round-robin result collection into a FIFO feeding indexed file writes; RESULT_WRITE_SCHEDULER_STATS_EN adds per-requester accept counters
module result_write_scheduler
    import wrs_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int DW         = DW_DEF,
    parameter int IW         = IW_DEF,
    parameter int FIFO_DEPTH = 8,
    parameter int LAST_INDEX = 1023
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
`ifdef RESULT_WRITE_SCHEDULER_STATS_EN
    output logic [NREQ*IW-1:0]   stat_cnt,
`endif
    output logic                 write_file,
    output logic [IW-1:0]        file_index,
    output logic [DW-1:0]        data_out,
    output logic                 busy,
    output logic                 done
);
    localparam int RW = NREQ > 1 ? $clog2(NREQ) : 1;
    state_t state, state_nx;
    logic [RW-1:0] rr_ptr, gnt_idx, rr_nx;
    logic [IW:0] acc_cnt;
    logic [IW-1:0] wr_cnt;
    logic found, accept, can_accept, start_run, pop, full, empty;
    logic [DW-1:0] fifo_dout;
    assign start_run  = start && (state == IDLE || state == DONE);
    assign can_accept = state == RUN && !full;
    assign accept     = found;
    assign pop        = !empty;
    assign busy       = state == RUN || state == DRAIN;
    assign done       = state == DONE;
    assign rr_nx      = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
    // round-robin search starting at rr_ptr; one-hot ready for the first valid requester
    always_comb begin
        found = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && can_accept && req_valid[(int'(rr_ptr) + k) % NREQ]) begin
                found = 1'b1;
                gnt_idx = RW'((int'(rr_ptr) + k) % NREQ);
            end
        end
        req_ready = '0;
        req_ready[gnt_idx] = found;
    end
    wrs_fifo #(.WIDTH(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk), .rst(rst), .push(accept), .pop(pop),
        .din(req_data[int'(gnt_idx)*DW +: DW]), .dout(fifo_dout), .full(full), .empty(empty)
    );
    // run sequencing: leave RUN on the final accept, leave DRAIN once the final index was written
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: if (start) state_nx = RUN;
            RUN:        if (accept && acc_cnt == (IW+1)'(LAST_INDEX)) state_nx = DRAIN;
            DRAIN:      if (write_file && file_index == IW'(LAST_INDEX)) state_nx = DONE;
            default:    state_nx = IDLE;
        endcase
    end
    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end
    // accept counter and round-robin pointer, cleared at the start of each run
    always_ff @(posedge clk) begin
        if (rst || start_run) begin
            acc_cnt <= '0;
            rr_ptr  <= '0;
        end else if (accept) begin
            acc_cnt <= acc_cnt + 1'b1;
            rr_ptr  <= rr_nx;
        end
    end
    // writer: pop the head every cycle the FIFO holds data and tag it with the next index
    always_ff @(posedge clk) begin
        if (rst) begin
            write_file <= 1'b0;
            file_index <= '0;
            data_out   <= '0;
            wr_cnt     <= '0;
        end else begin
            write_file <= pop;
            if (pop) begin
                data_out   <= fifo_dout;
                file_index <= wr_cnt;
                wr_cnt     <= wr_cnt + 1'b1;
            end
            if (start_run) wr_cnt <= '0;
        end
    end
`ifdef RESULT_WRITE_SCHEDULER_STATS_EN
    logic [NREQ-1:0][IW-1:0] stat_q;
    assign stat_cnt = stat_q;
    // per-requester accept counters, saturating at all-ones
    always_ff @(posedge clk) begin
        if (rst || start_run) stat_q <= '0;
        else if (accept && stat_q[gnt_idx] != '1) stat_q[gnt_idx] <= stat_q[gnt_idx] + 1'b1;
    end
`endif
endmodule
